// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle FETCH/WAIT/DECODE/EXEC control for the board's
// instruction datapath. It owns the PC and the instruction register, and it
// turns push-button presses into run, step, stop and PC-clear commands.
module cpu_sequencer #(
  parameter int unsigned PC_W     = 8,
  parameter int unsigned IR_W     = 16,
  parameter logic [3:0]  HALT_OPC = 4'hF,
  parameter logic [3:0]  JMP_OPC  = 4'hE
) (
  input  logic            i_CLK,
  input  logic            i_SYS_RESET,
  input  logic [4:0]      i_PB,
  output logic [PC_W-1:0] o_IM_ADDR,
  input  logic [IR_W-1:0] i_IM_DATA,
  output logic [IR_W-1:0] o_IR,
  output logic            o_DEC_EN,
  output logic            o_EXE_EN,
  output logic            o_RUNNING,
  output logic            o_HALTED,
  output logic [15:0]     o_INSTR_CNT
);

  localparam int unsigned PB_W  = 4;
  localparam int unsigned OPC_W = 4;
  localparam int unsigned CNT_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_DECODE = 3'd3,
    ST_EXEC   = 3'd4,
    ST_HALT   = 3'd5
  } state_e;

  // Button front end: two synchronizer stages, an edge register and a pulse register
  logic [PB_W-1:0]  pb_meta_q;
  logic [PB_W-1:0]  pb_sync_q;
  logic [PB_W-1:0]  pb_prev_q;
  logic [PB_W-1:0]  pb_pulse_q;
  logic             pb4_unused;

  // Sequencer state
  state_e           state_q;
  logic [PC_W-1:0]  pc_q;
  logic [IR_W-1:0]  ir_q;
  logic             dec_en_q;
  logic             exe_en_q;
  logic             run_q;
  logic             stop_pend_q;
  logic             halted_q;
  logic [CNT_W-1:0] cnt_q;

  logic             run_p;
  logic             step_p;
  logic             stop_p;
  logic             clr_p;
  logic [OPC_W-1:0] opc;
  logic             opc_ordinary;

  assign pb4_unused   = i_PB[4];
  assign run_p        = pb_pulse_q[0];
  assign step_p       = pb_pulse_q[1];
  assign stop_p       = pb_pulse_q[2];
  assign clr_p        = pb_pulse_q[3];
  assign opc          = ir_q[IR_W-1 -: OPC_W];
  assign opc_ordinary = (opc != HALT_OPC) && (opc != JMP_OPC);

  // Synchronize buttons and emit exactly one pulse per rising edge of a level
  always_ff @(posedge i_CLK or posedge i_SYS_RESET) begin
    if (i_SYS_RESET) begin
      pb_meta_q  <= '0;
      pb_sync_q  <= '0;
      pb_prev_q  <= '0;
      pb_pulse_q <= '0;
    end else begin
      pb_meta_q  <= i_PB[PB_W-1:0];
      pb_sync_q  <= pb_meta_q;
      pb_prev_q  <= pb_sync_q;
      pb_pulse_q <= pb_sync_q & ~pb_prev_q;
    end
  end

  // Instruction sequencer FSM with registered enables, PC, IR and retire count
  always_ff @(posedge i_CLK or posedge i_SYS_RESET) begin
    if (i_SYS_RESET) begin
      state_q     <= ST_IDLE;
      pc_q        <= '0;
      ir_q        <= '0;
      dec_en_q    <= 1'b0;
      exe_en_q    <= 1'b0;
      run_q       <= 1'b0;
      stop_pend_q <= 1'b0;
      halted_q    <= 1'b0;
      cnt_q       <= '0;
    end else begin
      dec_en_q <= 1'b0;
      exe_en_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (clr_p) begin
            pc_q <= '0;
          end else if (stop_p) begin
            state_q <= ST_IDLE;
          end else if (run_p) begin
            run_q   <= 1'b1;
            state_q <= ST_FETCH;
          end else if (step_p) begin
            run_q   <= 1'b0;
            state_q <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (stop_p) stop_pend_q <= 1'b1;
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (stop_p) stop_pend_q <= 1'b1;
          ir_q     <= i_IM_DATA;
          dec_en_q <= 1'b1;
          state_q  <= ST_DECODE;
        end
        ST_DECODE: begin
          if (stop_p) stop_pend_q <= 1'b1;
          exe_en_q <= opc_ordinary;
          state_q  <= ST_EXEC;
        end
        ST_EXEC: begin
          if (opc == HALT_OPC) begin
            run_q       <= 1'b0;
            stop_pend_q <= 1'b0;
            halted_q    <= 1'b1;
            state_q     <= ST_HALT;
          end else begin
            if (opc == JMP_OPC) begin
              pc_q <= ir_q[PC_W-1:0];
            end else begin
              pc_q <= pc_q + PC_W'(1);
            end
            cnt_q <= cnt_q + CNT_W'(1);
            if (run_q && !(stop_pend_q || stop_p)) begin
              state_q <= ST_FETCH;
            end else begin
              run_q       <= 1'b0;
              stop_pend_q <= 1'b0;
              state_q     <= ST_IDLE;
            end
          end
        end
        ST_HALT: begin
          if (clr_p) begin
            pc_q     <= '0;
            halted_q <= 1'b0;
            state_q  <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_IM_ADDR   = pc_q;
  assign o_IR        = ir_q;
  assign o_DEC_EN    = dec_en_q;
  assign o_EXE_EN    = exe_en_q;
  assign o_RUNNING   = run_q;
  assign o_HALTED    = halted_q;
  assign o_INSTR_CNT = cnt_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: directed scenarios plus randomized programs checked
// against an instruction-level reference model of the sequencer.
module tb_cpu_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  pb;
  logic [7:0]  im_addr;
  logic [15:0] im_data;
  logic [15:0] ir;
  logic        dec_en;
  logic        exe_en;
  logic        running;
  logic        halted;
  logic [15:0] instr_cnt;

  logic [15:0] mem [256];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int dec_seen = 0;
  int exe_seen = 0;
  int exe_stamps[$];

  localparam logic [4:0] PB_RUN  = 5'b00001;
  localparam logic [4:0] PB_STEP = 5'b00010;
  localparam logic [4:0] PB_STOP = 5'b00100;
  localparam logic [4:0] PB_CLR  = 5'b01000;

  cpu_sequencer dut (
    .i_CLK       (clk),
    .i_SYS_RESET (rst),
    .i_PB        (pb),
    .o_IM_ADDR   (im_addr),
    .i_IM_DATA   (im_data),
    .o_IR        (ir),
    .o_DEC_EN    (dec_en),
    .o_EXE_EN    (exe_en),
    .o_RUNNING   (running),
    .o_HALTED    (halted),
    .o_INSTR_CNT (instr_cnt)
  );

  always #5 clk = ~clk;

  // Synchronous-read instruction BRAM with one cycle of latency
  always @(posedge clk) im_data <= mem[im_addr];

  // Count enable pulses using the value held during the cycle that just ended
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (dec_en) dec_seen <= dec_seen + 1;
    if (exe_en) begin
      exe_seen <= exe_seen + 1;
      exe_stamps.push_back(cyc);
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [4:0] bits, input int hold);
    @(negedge clk);
    pb = bits;
    repeat (hold) @(negedge clk);
    pb = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    pb  = '0;
    rst = 1'b1;
    wait_cycles(3);
    rst = 1'b0;
    wait_cycles(2);
  endtask

  task automatic clear_mem();
    for (int a = 0; a < 256; a++) mem[a] = 16'h0000;
  endtask

  task automatic wait_for_halt(input int budget);
    int n = 0;
    while (!halted && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("halt_wait", 32'(halted), 32'd1);
  endtask

  function automatic logic [15:0] rand_word();
    int unsigned r = $urandom_range(0, 99);
    logic [11:0] lo = 12'($urandom);
    if (r < 8)  return {4'hF, lo};
    if (r < 20) return {4'hE, lo};
    return {4'($urandom_range(0, 13)), lo};
  endfunction

  // Instruction-level model state
  logic [7:0]  m_pc;
  logic [15:0] m_cnt;
  logic [15:0] m_ir;
  logic        m_halt;
  int          m_exe;
  int          d0;
  int          e0;
  int          s0;

  initial begin
    rst = 1'b1;
    pb  = '0;
    clear_mem();
    #1;
    check("rst_addr", 32'(im_addr), 32'd0);
    check("rst_ir", 32'(ir), 32'd0);
    check("rst_en", 32'({dec_en, exe_en}), 32'd0);
    check("rst_flags", 32'({running, halted}), 32'd0);
    check("rst_cnt", 32'(instr_cnt), 32'd0);
    wait_cycles(3);
    rst = 1'b0;
    wait_cycles(2);

    // Single step of one ordinary instruction
    mem[0] = 16'h1234;
    d0 = dec_seen; e0 = exe_seen;
    press(PB_STEP, 1);
    wait_cycles(10);
    check("step_addr", 32'(im_addr), 32'd1);
    check("step_ir", 32'(ir), 32'h1234);
    check("step_dec", 32'(dec_seen - d0), 32'd1);
    check("step_exe", 32'(exe_seen - e0), 32'd1);
    check("step_cnt", 32'(instr_cnt), 32'd1);
    check("step_run", 32'(running), 32'd0);

    // Run to a HALT opcode
    clear_mem();
    mem[0] = 16'h1111; mem[1] = 16'h2222; mem[2] = 16'h3333; mem[3] = 16'hF000;
    do_reset();
    e0 = exe_seen; s0 = exe_stamps.size();
    press(PB_RUN, 1);
    wait_for_halt(40);
    check("run_exe", 32'(exe_seen - e0), 32'd3);
    if (exe_stamps.size() >= s0 + 3) begin
      check("run_gap0", 32'(exe_stamps[s0+1] - exe_stamps[s0]), 32'd4);
      check("run_gap1", 32'(exe_stamps[s0+2] - exe_stamps[s0+1]), 32'd4);
    end
    check("halt_pc", 32'(im_addr), 32'd3);
    check("halt_cnt", 32'(instr_cnt), 32'd3);
    check("halt_run", 32'(running), 32'd0);
    check("halt_ir", 32'(ir), 32'hF000);
    press(PB_RUN, 1);
    wait_cycles(10);
    check("halt_ign_run", 32'({halted, instr_cnt}), {15'd0, 1'b1, 16'd3});
    press(PB_CLR, 1);
    wait_cycles(8);
    check("clr_pc", 32'(im_addr), 32'd0);
    check("clr_halt", 32'(halted), 32'd0);

    // Absolute jump, then PC wrap at the top of the address space
    clear_mem();
    mem[0] = 16'hE0FE; mem[8'hFE] = 16'h1000; mem[8'hFF] = 16'h2000;
    do_reset();
    e0 = exe_seen;
    press(PB_STEP, 1); wait_cycles(10);
    check("jmp_pc", 32'(im_addr), 32'hFE);
    check("jmp_noexe", 32'(exe_seen - e0), 32'd0);
    press(PB_STEP, 1); wait_cycles(10);
    check("fe_pc", 32'(im_addr), 32'hFF);
    press(PB_STEP, 1); wait_cycles(10);
    check("wrap_pc", 32'(im_addr), 32'h00);
    check("wrap_exe", 32'(exe_seen - e0), 32'd2);
    check("wrap_cnt", 32'(instr_cnt), 32'd3);

    // Stop pulse reaching the sequencer in DECODE of the instruction at PC 5
    clear_mem();
    do_reset();
    e0 = exe_seen;
    press(PB_RUN, 1);
    begin
      int n = 0;
      while (!(exe_en && im_addr == 8'd4) && n < 60) begin
        @(negedge clk);
        n++;
      end
      check("stop_sync", 32'({exe_en, im_addr}), {23'd0, 1'b1, 8'd4});
    end
    pb = PB_STOP;
    @(negedge clk);
    pb = '0;
    wait_cycles(15);
    check("stop_pc", 32'(im_addr), 32'd6);
    check("stop_cnt", 32'(instr_cnt), 32'd6);
    check("stop_exe", 32'(exe_seen - e0), 32'd6);
    check("stop_run", 32'(running), 32'd0);

    // Run and step on the same edge; PC clear ignored while running
    do_reset();
    press(PB_RUN | PB_STEP, 1);
    wait_cycles(8);
    check("runstep_run", 32'(running), 32'd1);
    press(PB_CLR, 1);
    wait_cycles(10);
    check("clr_run_ign", 32'(running), 32'd1);
    press(PB_STOP, 1);
    wait_cycles(15);
    check("runstop_run", 32'(running), 32'd0);
    check("runstop_nz", 32'(instr_cnt != 16'd0), 32'd1);
    check("runstop_pc", 32'(im_addr), 32'(instr_cnt[7:0]));

    // A long hold yields a single step
    do_reset();
    d0 = dec_seen; e0 = exe_seen;
    press(PB_STEP, 100);
    wait_cycles(10);
    check("hold_dec", 32'(dec_seen - d0), 32'd1);
    check("hold_exe", 32'(exe_seen - e0), 32'd1);
    check("hold_cnt", 32'(instr_cnt), 32'd1);

    // PC clear beats run when both arrive together
    d0 = dec_seen;
    press(PB_CLR | PB_RUN, 1);
    wait_cycles(10);
    check("prio_pc", 32'(im_addr), 32'd0);
    check("prio_run", 32'(running), 32'd0);
    check("prio_dec", 32'(dec_seen - d0), 32'd0);

    // Asynchronous reset while in WAIT
    clear_mem();
    mem[0] = 16'hABCD; mem[1] = 16'h5555;
    do_reset();
    press(PB_STEP, 1);
    wait_cycles(10);
    check("pre_rst_ir", 32'(ir), 32'hABCD);
    @(negedge clk);
    pb = PB_STEP;
    @(negedge clk);
    pb = '0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("arst_addr", 32'(im_addr), 32'd0);
    check("arst_ir", 32'(ir), 32'd0);
    check("arst_cnt", 32'(instr_cnt), 32'd0);
    check("arst_misc", 32'({dec_en, exe_en, running, halted}), 32'd0);
    d0 = dec_seen; e0 = exe_seen;
    wait_cycles(3);
    rst = 1'b0;
    wait_cycles(20);
    check("arst_noen", 32'((dec_seen - d0) + (exe_seen - e0)), 32'd0);

    // Random step/clear sequence against the instruction-level model
    for (int a = 0; a < 256; a++) mem[a] = rand_word();
    do_reset();
    m_pc = 8'd0; m_cnt = 16'd0; m_ir = 16'd0; m_halt = 1'b0; m_exe = 0;
    e0 = exe_seen;
    for (int it = 0; it < 40; it++) begin
      logic do_clr;
      do_clr = ($urandom_range(0, 5) == 0);
      press(do_clr ? PB_CLR : PB_STEP, $urandom_range(1, 3));
      wait_cycles(12);
      if (do_clr) begin
        m_pc = 8'd0;
        m_halt = 1'b0;
      end else if (!m_halt) begin
        m_ir = mem[m_pc];
        if (m_ir[15:12] == 4'hF) begin
          m_halt = 1'b1;
        end else if (m_ir[15:12] == 4'hE) begin
          m_pc = m_ir[7:0];
          m_cnt++;
        end else begin
          m_pc = m_pc + 8'd1;
          m_cnt++;
          m_exe++;
        end
      end
      check("rs_pc", 32'(im_addr), 32'(m_pc));
      check("rs_ir", 32'(ir), 32'(m_ir));
      check("rs_cnt", 32'(instr_cnt), 32'(m_cnt));
      check("rs_exe", 32'(exe_seen - e0), 32'(m_exe));
      check("rs_halt", 32'(halted), 32'(m_halt));
    end

    // Random programs run to completion
    for (int r = 0; r < 3; r++) begin
      int n;
      m_halt = 1'b0;
      for (int t = 0; t < 20 && !m_halt; t++) begin
        for (int a = 0; a < 256; a++) mem[a] = rand_word();
        m_pc = 8'd0; m_cnt = 16'd0; m_exe = 0; n = 0;
        while (n < 120 && !m_halt) begin
          m_ir = mem[m_pc];
          if (m_ir[15:12] == 4'hF) begin
            m_halt = 1'b1;
          end else begin
            if (m_ir[15:12] == 4'hE) m_pc = m_ir[7:0];
            else begin
              m_pc = m_pc + 8'd1;
              m_exe++;
            end
            m_cnt++;
            n++;
          end
        end
      end
      if (!m_halt) begin
        mem[0] = 16'hF000;
        m_pc = 8'd0; m_cnt = 16'd0; m_exe = 0; n = 0; m_ir = 16'hF000;
      end
      do_reset();
      e0 = exe_seen;
      press(PB_RUN, 1);
      wait_for_halt(n * 4 + 40);
      check("rr_pc", 32'(im_addr), 32'(m_pc));
      check("rr_cnt", 32'(instr_cnt), 32'(m_cnt));
      check("rr_exe", 32'(exe_seen - e0), 32'(m_exe));
      check("rr_ir", 32'(ir), 32'(m_ir));
      check("rr_run", 32'(running), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
